// File: rtl/aes_key_expander.sv
// AES key-schedule engine for AES-128/192/256.
//
// A cipher key is accepted through a valid/ready handshake and expanded one
// 32-bit word per clock into an internal schedule register file. Any round key
// can then be read combinationally by round index.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   key_in      cipher key, word 0 in the most significant 32 bits
//   key_valid   key_in is valid
//   key_ready   a key is accepted this cycle if key_valid is high
//   busy        expansion in progress
//   keys_valid  full schedule present and readable
//   rd_round    round index to read (0..NR)
//   rd_key      round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, zero when not readable
//   rd_error    rd_round is beyond the last round
module aes_key_expander #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic                busy,
  output logic                keys_valid,
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key,
  output logic                rd_error
);

  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned CW = $clog2(NW);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  // Forward S-box, entry 0 in the most significant byte; indexed with ~x below.
  localparam logic [255:0][7:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTable[~x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;     // index i of the next word to write
  logic [2:0]      phase_q, phase_d; // i mod NK, tracked incrementally
  logic [7:0]      rcon_q, rcon_d;   // rcon[i/NK] for the next i with phase 0
  logic            kv_q, kv_d;
  logic [31:0]     w_q [NW];

  logic            load_key;
  logic            wr_word;
  logic [31:0]     prev_word;
  logic [31:0]     back_word;
  logic [31:0]     sbox_in;
  logic [31:0]     sbox_out;
  logic [31:0]     temp;
  logic [31:0]     new_word;

  // Word-generation datapath: the four S-boxes below are shared by the RotWord
  // path (phase 0) and the AES-256 mid-key path (phase 4).
  always_comb begin
    prev_word = w_q[cnt_q - CW'(1)];
    back_word = w_q[cnt_q - CW'(NK)];
    sbox_in   = (phase_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sbox_out[8*b +: 8] = sbox(sbox_in[8*b +: 8]);
  end

  always_comb begin
    temp = prev_word;
    if (phase_q == 3'd0) begin
      temp = sbox_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && phase_q == 3'd4) begin
      temp = sbox_out;
    end
    new_word = back_word ^ temp;
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    rcon_d   = rcon_q;
    kv_d     = kv_q;
    load_key = 1'b0;
    wr_word  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (key_valid) begin
          load_key = 1'b1;
          state_d  = StExpand;
          cnt_d    = CW'(NK);
          phase_d  = 3'd0;
          rcon_d   = 8'h01;
          kv_d     = 1'b0;
        end
      end
      StExpand: begin
        wr_word = 1'b1;
        phase_d = (phase_q == 3'(NK - 1)) ? 3'd0 : phase_q + 3'd1;
        if (phase_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (cnt_q == CW'(NW - 1)) begin
          // Counter holds at the last index while in StDone.
          state_d = StDone;
          kv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      phase_q <= '0;
      rcon_q  <= '0;
      kv_q    <= 1'b0;
      for (int j = 0; j < NW; j++) begin
        w_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rcon_q  <= rcon_d;
      kv_q    <= kv_d;
      if (load_key) begin
        for (int j = 0; j < NK; j++) begin
          w_q[j] <= key_in[KEY_BITS-1-32*j -: 32];
        end
      end
      if (wr_word) begin
        w_q[cnt_q] <= new_word;
      end
    end
  end

  // Handshake and status outputs.
  always_comb begin
    key_ready  = (state_q != StExpand);
    busy       = (state_q == StExpand);
    keys_valid = kv_q;
  end

  // Read port: purely combinational, gated by a complete schedule.
  logic [CW-1:0] rd_base;

  always_comb begin
    rd_base  = CW'({rd_round, 2'b00});
    rd_error = (32'(rd_round) > NR);
    rd_key   = '0;
    if (kv_q && !rd_error) begin
      rd_key = {w_q[rd_base], w_q[rd_base + CW'(1)], w_q[rd_base + CW'(2)],
                w_q[rd_base + CW'(3)]};
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: three instances (AES-128/192/256)
// checked against FIPS-197 vectors and an arithmetic key-schedule model.
module tb_aes_key_expander;

  logic              clk = 1'b0;
  logic              rst;
  logic [127:0]      key128;
  logic [191:0]      key192;
  logic [255:0]      key256;
  logic [2:0]        kval;
  logic [2:0]        rdy;
  logic [2:0]        bsy;
  logic [2:0]        kv;
  logic [2:0]        err;
  logic [3:0]        rd_round;
  logic [2:0][127:0] rk;

  always #5 clk = ~clk;

  aes_key_expander #(.KEY_BITS(128)) u_aes128 (
    .clk(clk), .rst(rst), .key_in(key128), .key_valid(kval[0]), .key_ready(rdy[0]),
    .busy(bsy[0]), .keys_valid(kv[0]), .rd_round(rd_round), .rd_key(rk[0]), .rd_error(err[0])
  );
  aes_key_expander #(.KEY_BITS(192)) u_aes192 (
    .clk(clk), .rst(rst), .key_in(key192), .key_valid(kval[1]), .key_ready(rdy[1]),
    .busy(bsy[1]), .keys_valid(kv[1]), .rd_round(rd_round), .rd_key(rk[1]), .rd_error(err[1])
  );
  aes_key_expander #(.KEY_BITS(256)) u_aes256 (
    .clk(clk), .rst(rst), .key_in(key256), .key_valid(kval[2]), .key_ready(rdy[2]),
    .busy(bsy[2]), .keys_valid(kv[2]), .rd_round(rd_round), .rd_key(rk[2]), .rd_error(err[2])
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  sb [256];
  logic [31:0] ref_w [3][60];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < j; k++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic ref_expand(input int m, input logic [255:0] key);
    int nk;
    int nw;
    logic [31:0] t;
    nk = 4 + 2 * m;
    nw = 4 * (nk + 7);
    for (int i = 0; i < 60; i++) ref_w[m][i] = 32'h0;
    for (int i = 0; i < nk; i++) ref_w[m][i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = ref_w[m][i-1];
      if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4) t = sub_word(t);
      ref_w[m][i] = ref_w[m][i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_rk(input int m, input int r);
    if (r > 10 + 2 * m) return 128'h0;
    return {ref_w[m][4*r], ref_w[m][4*r+1], ref_w[m][4*r+2], ref_w[m][4*r+3]};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_key(input int m, input logic [255:0] k);
    case (m)
      0: key128 = k[255 -: 128];
      1: key192 = k[255 -: 192];
      default: key256 = k;
    endcase
  endtask

  task automatic check_read(input int m, input int r, input bit done, input string tag);
    logic [127:0] exp_key;
    rd_round = 4'(r);
    #1;
    exp_key = done ? ref_rk(m, r) : 128'h0;
    chk($sformatf("%s_key m%0d r%0d", tag, m, r), rk[m], exp_key);
    chk($sformatf("%s_err m%0d r%0d", tag, m, r), 128'(err[m]), 128'(r > 10 + 2 * m));
  endtask

  // Called at the first negedge after an accept edge; counts edges to keys_valid.
  task automatic wait_done(input int m, output int lat);
    lat = 0;
    chk("kv_low_after_accept", 128'(kv[m]), 128'(1'b0));
    chk("busy_after_accept", 128'(bsy[m]), 128'(1'b1));
    while (kv[m] !== 1'b1 && lat < 200) begin
      chk("ready_low_in_expand", 128'(rdy[m]), 128'(1'b0));
      check_read(m, lat % 16, 1'b0, "gate");
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency m%0d", m), 128'(lat), 128'(3 * (4 + 2 * m) + 28));
  endtask

  task automatic run_key(input int m, input logic [255:0] k);
    int lat;
    @(negedge clk);
    set_key(m, k);
    kval[m] = 1'b1;
    #1;
    chk("ready_before_accept", 128'(rdy[m]), 128'(1'b1));
    @(negedge clk);
    kval[m] = 1'b0;
    set_key(m, ~k);
    ref_expand(m, k);
    wait_done(m, lat);
  endtask

  task automatic sweep_done(input int m, input string tag);
    for (int r = 0; r < 16; r++) check_read(m, r, 1'b1, tag);
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    int           m;
    logic [255:0] key;
    int           round;
    logic [127:0] exp_key;
    bit           exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] cur [3];
    bit           loaded [3];
    logic [255:0] ka;
    logic [255:0] kb;
    int           lat;

    vecs[0] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0,
                128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0};
    vecs[1] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1,
                128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
    vecs[2] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 10,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
    vecs[3] = '{1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 12,
                128'he98ba06f448c773c8ecc720401002202, 1'b0};
    vecs[4] = '{1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 13,
                128'h0, 1'b1};
    vecs[5] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 14,
                128'hfe4890d1e6188d0b046df344706c631e, 1'b0};

    build_sbox();
    rst = 1'b1;
    kval = 3'b000;
    key128 = '0;
    key192 = '0;
    key256 = '0;
    rd_round = 4'd0;
    for (int m = 0; m < 3; m++) loaded[m] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    for (int m = 0; m < 3; m++) begin
      chk("rst_ready", 128'(rdy[m]), 128'(1'b1));
      chk("rst_busy", 128'(bsy[m]), 128'(1'b0));
      chk("rst_kv", 128'(kv[m]), 128'(1'b0));
      check_read(m, 0, 1'b0, "rst");
      check_read(m, 15, 1'b0, "rst");
    end

    // FIPS-197 vectors
    for (int v = 0; v < 6; v++) begin
      if (!loaded[vecs[v].m] || cur[vecs[v].m] != vecs[v].key) begin
        run_key(vecs[v].m, vecs[v].key);
        cur[vecs[v].m] = vecs[v].key;
        loaded[vecs[v].m] = 1'b1;
      end
      rd_round = 4'(vecs[v].round);
      #1;
      chk($sformatf("fips_key v%0d", v), rk[vecs[v].m], vecs[v].exp_key);
      chk($sformatf("fips_err v%0d", v), 128'(err[vecs[v].m]), 128'(vecs[v].exp_err));
      chk($sformatf("model_key v%0d", v), rk[vecs[v].m], ref_rk(vecs[v].m, vecs[v].round));
    end
    sweep_done(2, "a3_done");

    // Handshake: second key held during EXPAND is ignored, then taken from DONE
    ka = rand_key();
    kb = rand_key();
    @(negedge clk);
    set_key(0, ka);
    kval[0] = 1'b1;
    @(negedge clk);
    set_key(0, kb);
    ref_expand(0, ka);
    lat = 0;
    while (kv[0] !== 1'b1 && lat < 200) begin
      chk("hs_ready_low", 128'(rdy[0]), 128'(1'b0));
      @(negedge clk);
      lat++;
    end
    chk("hs_latency_a", 128'(lat), 128'(40));
    chk("hs_ready_done", 128'(rdy[0]), 128'(1'b1));
    rd_round = 4'd10;
    #1;
    chk("hs_first_key_r10", rk[0], ref_rk(0, 10));
    rd_round = 4'd1;
    #1;
    chk("hs_first_key_r1", rk[0], ref_rk(0, 1));
    @(negedge clk);
    kval[0] = 1'b0;
    ref_expand(0, kb);
    wait_done(0, lat);
    sweep_done(0, "hs_second");

    // Reset mid-expansion, reset beating key_valid, then a fresh key
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      set_key(m, rand_key());
      kval[m] = 1'b1;
      @(negedge clk);
      kval[m] = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_busy", 128'(bsy[m]), 128'(1'b0));
      chk("midrst_kv", 128'(kv[m]), 128'(1'b0));
      chk("midrst_ready", 128'(rdy[m]), 128'(1'b1));
      for (int r = 0; r < 16; r++) check_read(m, r, 1'b0, "midrst");
      @(negedge clk);
      rst = 1'b1;
      kval[m] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      kval[m] = 1'b0;
      #1;
      chk("rst_vs_key_busy", 128'(bsy[m]), 128'(1'b0));
      chk("rst_vs_key_ready", 128'(rdy[m]), 128'(1'b1));
      run_key(m, rand_key());
      sweep_done(m, "after_rst");
    end

    // Random keys against the model
    for (int m = 0; m < 3; m++) begin
      for (int n = 0; n < 3; n++) begin
        run_key(m, rand_key());
        sweep_done(m, "rand");
        for (int k = 0; k < 4; k++) check_read(m, $urandom_range(15, 0), 1'b1, "rand_rd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
